bus_arb4: RTL
=============

BUS_ARB4 -- requirements
Module: bus_arb4

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning write/read data width.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock for all state.
REQ-004 SHALL have: rst  in  1  synchronous active-high reset.
REQ-005 SHALL have: req_valid  in  4  per-requester request strobe, held until accepted.
REQ-006 SHALL have: req_addr0..3  in  ADDR_W each  per-requester address.
REQ-007 SHALL have: req_wdata0..3  in  DATA_W each  per-requester write data.
REQ-008 SHALL have: req_we  in  4  per-requester write enable (1 = write).
REQ-009 SHALL have: req_ready  out  4  one-hot acceptance pulse to the winning requester.
REQ-010 SHALL have: rsp_valid  out  4  one-hot completion pulse to the owning requester.
REQ-011 SHALL have: rsp_rdata  out  DATA_W  read data, valid with any rsp_valid bit.
REQ-012 SHALL have: mem_valid / mem_ready  out / in  1 / 1  shared-port command handshake.
REQ-013 SHALL have: mem_addr, mem_wdata, mem_we  out  ADDR_W, DATA_W, 1  registered command fields.
REQ-014 SHALL have: mem_rsp_valid, mem_rdata  in  1, DATA_W  shared-port response (reads and write acks).
REQ-015 SHALL have: grant_id  out  2  index of current owner; busy  out  1  high outside IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT_RSP.
REQ-017 SHALL, in IDLE with any req_valid bit set, choose the first set bit scanning from (last_grant+1) mod 4 upward with wrap-around.
REQ-018 SHALL, on that choice, pulse req_ready[winner] for exactly that cycle, register winner into grant_id, capture winner's addr/wdata/we into mem_addr/mem_wdata/mem_we, and enter ISSUE next cycle.
REQ-019 SHALL drive mem_valid=1 throughout ISSUE with mem_* fields stable; request at cycle N in IDLE gives mem_valid at N+1.
REQ-020 SHALL leave ISSUE for WAIT_RSP on the cycle mem_valid && mem_ready; mem_valid=0 from the next cycle.
REQ-021 SHALL ignore mem_rsp_valid in IDLE and ISSUE.
REQ-022 SHALL, in WAIT_RSP on mem_rsp_valid, combinationally assert rsp_valid[grant_id] for that cycle with rsp_rdata=mem_rdata, update last_grant=grant_id, and enter IDLE.
REQ-023 SHALL hold rsp_valid=0 in all other cycles; rsp_rdata is don't-care when rsp_valid=0 but SHALL equal mem_rdata (pass-through).
REQ-024 SHALL spend at least one IDLE cycle between transactions; minimum transaction = 3 cycles (grant, issue, response).
REQ-025 SHALL ignore requester input changes after acceptance (fields already captured); a requester dropping req_valid before acceptance is never granted.
REQ-026 SHALL keep req_ready=0 for all requesters outside the IDLE grant cycle.
REQ-027 SHALL give every continuously requesting requester a grant within 4 transactions (no starvation).

Reset
REQ-028 SHALL, on rst high at a clock edge, enter IDLE and set last_grant=3 (requester 0 highest priority), grant_id=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_we=0, req_ready=0, rsp_valid=0, busy=0.
REQ-029 SHALL, on reset mid-ISSUE or mid-WAIT_RSP, abandon the transaction with no rsp_valid pulse; a later stray mem_rsp_valid in IDLE is ignored.

Structure
REQ-030 SHALL take the FSM state enum, N_REQ=4, and ID_W=2 from shared package arb_pkg.
REQ-031 SHALL instantiate the team's mux4 (WIDTH=ADDR_W, and WIDTH=DATA_W) with sel = combinational winner index to select captured addr and wdata.
REQ-032 SHALL contain the round-robin pick as a pure function; no other sub-modules.

Verification
REQ-033 Reset: rst high 2 cycles, req_valid=4'b1111 -> all outputs at REQ-028 values; first cycle after reset grants requester 0.
REQ-034 Round-robin: req_valid=4'b1111 held, mem_ready=1, mem_rsp_valid 1 cycle after issue -> grant order 0,1,2,3,0; one transaction every 3 cycles.
REQ-035 Backpressure: requester 2 read addr 0x100, mem_ready low 5 cycles -> mem_valid held high, mem_addr stable 0x100 for 6 cycles; rsp_valid=4'b0100 with rsp_rdata=0xDEADBEEF on response.
REQ-036 Wrap/skip: last_grant=3, req_valid=4'b0100 -> grant_id=2; then req_valid=4'b0011 -> grant_id=0.
REQ-037 Reset mid-op: rst during WAIT_RSP, then mem_rsp_valid pulse -> no rsp_valid bit asserted; state IDLE.
REQ-038 Write: requester 1 we=1, wdata=0x12345678, addr=0x40 -> mem_we=1, mem_wdata=0x12345678; ack gives rsp_valid=4'b0010.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way shared-port bus arbiter.
// Holds the FSM encoding and the round-robin pick.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RSP
  } state_t;

  // First set bit strictly after 'last', wrapping; 'last' itself is
  // checked at lowest priority. Returns 'last' if nothing is set.
  function automatic logic [ID_W-1:0] rr_pick(
    input logic [N_REQ-1:0] v,
    input logic [ID_W-1:0]  last
  );
    logic [ID_W-1:0] idx;
    rr_pick = last;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last + i[ID_W-1:0];
      if (v[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux4.sv
// Generic 4:1 multiplexer.
// Used to pick the winning requester's command fields.
module mux4 #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/bus_arb4.sv
// Round-robin arbiter: four requesters share one memory port,
// one outstanding transaction at a time.
module bus_arb4
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [ADDR_W-1:0]   req_addr0,
  input  logic [ADDR_W-1:0]   req_addr1,
  input  logic [ADDR_W-1:0]   req_addr2,
  input  logic [ADDR_W-1:0]   req_addr3,
  input  logic [DATA_W-1:0]   req_wdata0,
  input  logic [DATA_W-1:0]   req_wdata1,
  input  logic [DATA_W-1:0]   req_wdata2,
  input  logic [DATA_W-1:0]   req_wdata3,
  input  logic [N_REQ-1:0]    req_we,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy
);

  state_t          state, state_n;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] win;
  logic            grant;
  logic            done;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  assign win = rr_pick(req_valid, last_grant);

  mux4 #(.WIDTH(ADDR_W)) u_addr_mux (
    .sel (win),
    .d0  (req_addr0),
    .d1  (req_addr1),
    .d2  (req_addr2),
    .d3  (req_addr3),
    .y   (addr_sel)
  );

  mux4 #(.WIDTH(DATA_W)) u_wdata_mux (
    .sel (win),
    .d0  (req_wdata0),
    .d1  (req_wdata1),
    .d2  (req_wdata2),
    .d3  (req_wdata3),
    .y   (wdata_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      grant_id   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
    end else begin
      state <= state_n;
      if (grant) begin
        grant_id  <= win;
        mem_addr  <= addr_sel;
        mem_wdata <= wdata_sel;
        mem_we    <= req_we[win];
      end
      if (done) last_grant <= grant_id;
    end
  end

  // Handshake pulses are masked by rst so nothing leaks out
  // while the block is being reset.
  always_comb begin
    state_n   = state;
    grant     = 1'b0;
    done      = 1'b0;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state)
      S_IDLE: begin
        if (|req_valid && !rst) begin
          grant   = 1'b1;
          state_n = S_ISSUE;
          req_ready = N_REQ'(1) << win;
        end
      end
      S_ISSUE: begin
        if (mem_ready) state_n = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (mem_rsp_valid && !rst) begin
          done      = 1'b1;
          state_n   = S_IDLE;
          rsp_valid = N_REQ'(1) << grant_id;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign mem_valid = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);
  assign rsp_rdata = mem_rdata;

endmodule
